// File: rtl/cim_sched_pkg.sv
// cim_sched_pkg: scheduler state encoding, the array's state codes seen on cim_state,
// and the array read latency shared by the scheduler files.
package cim_sched_pkg;
    typedef enum logic [2:0] {IDLE, ACCUM, SWAP_ISSUE, SWAP_WAIT, SWEEP, FLUSH} sched_state_t;
    localparam logic [1:0] CIM_WAIT_TAG = 2'd0;
    localparam logic [1:0] CIM_SWAP     = 2'd2;
    localparam int         READ_LAT     = 2;
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: show-ahead FIFO of neuron tags; push and pop in the same cycle are both
// honoured, so a full FIFO can accept a push alongside a pop.
module tag_fifo #(
    parameter int W          = 5,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    logic [W-1:0]        r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] r_wr, r_rd;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= r_wr + {{DEPTH_LOG2{1'b0}}, i_push};
            r_rd <= r_rd + {{DEPTH_LOG2{1'b0}}, i_pop};
        end

    always_ff @(posedge clk)
        if (i_push) r_mem[r_wr[DEPTH_LOG2-1:0]] <= i_din;

    assign o_dout  = r_mem[r_rd[DEPTH_LOG2-1:0]];
    assign o_empty = r_wr == r_rd;
    // Pointers carry one extra wrap bit: equal low bits with differing wrap bit means full.
    assign o_full  = (r_wr ^ r_rd) == {1'b1, {DEPTH_LOG2{1'b0}}};
endmodule

// File: rtl/cim_step_scheduler.sv
// cim_step_scheduler: sequences one compute-in-memory array per timestep (weights, spikes,
// swap, current sweep). Define CIM_SCHED_STATS_EN for per-step spike/cycle statistics.
module cim_step_scheduler
    import cim_sched_pkg::*;
#(
    parameter int NUMWIDTH        = 16,
    parameter int TAGBITS         = 5,
    parameter int FIFO_DEPTH_LOG2 = 5,
    parameter int STEPBITS        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_start,
    output logic                step_done,
    output logic [STEPBITS-1:0] step_count,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [TAGBITS-1:0]  cfg_eff,
    input  logic [TAGBITS-1:0]  cfg_aff,
    input  logic [NUMWIDTH:0]   cfg_weight,
    input  logic                spike_valid,
    input  logic [TAGBITS-1:0]  spike_tag,
    output logic                spike_ready,
    output logic                spike_ovf,
    output logic                cur_valid,
    output logic [TAGBITS-1:0]  cur_tag,
    output logic [NUMWIDTH:0]   cur_data,
    output logic                cim_ld_en,
    output logic [TAGBITS-1:0]  cim_eff_tag,
    output logic [TAGBITS-1:0]  cim_aff_tag,
    output logic [NUMWIDTH:0]   cim_ld_weight,
    output logic                cim_fifo_empty,
    output logic [TAGBITS-1:0]  cim_fired_tag,
    input  logic                cim_req_deq,
    output logic                cim_swap,
    output logic                cim_read_en,
    output logic [TAGBITS-1:0]  cim_i_tag,
`ifdef CIM_SCHED_STATS_EN
    output logic [15:0]         stat_spikes,
    output logic [15:0]         stat_cycles,
`endif
    input  logic                cim_busy,
    input  logic [1:0]          cim_state,
    input  logic [NUMWIDTH:0]   cim_i_out
);
    localparam int NUMNEURONS = 2**TAGBITS;

    sched_state_t        r_state, w_next;
    logic [TAGBITS-1:0]  r_k;
    logic [1:0]          r_fl;
    logic                r_seen_swap;
    logic [READ_LAT-1:0] r_rv;
    logic [TAGBITS-1:0]  r_rt [READ_LAT];
    logic                r_done, r_ovf;
    logic [STEPBITS-1:0] r_cnt;
    logic                w_full, w_empty, w_push, w_pop, w_rd, w_fin;
    logic [TAGBITS-1:0]  w_head;

    assign w_pop  = cim_req_deq & ~w_empty;
    assign w_push = spike_valid & reset & (~w_full | w_pop);
    assign w_rd   = r_state == SWEEP;
    assign w_fin  = r_state == FLUSH && r_fl == 2'(READ_LAT-1);

    tag_fifo #(.W(TAGBITS), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
        .clk(clk), .reset(reset), .i_push(w_push), .i_pop(w_pop), .i_din(spike_tag),
        .o_dout(w_head), .o_full(w_full), .o_empty(w_empty)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       w_next = step_start ? ACCUM : IDLE;
            ACCUM:      w_next = (w_empty & ~cim_busy & ~cim_req_deq) ? SWAP_ISSUE : ACCUM;
            SWAP_ISSUE: w_next = (cim_state == CIM_WAIT_TAG) ? SWAP_WAIT : SWAP_ISSUE;
            SWAP_WAIT:  w_next = (r_seen_swap && cim_state == CIM_WAIT_TAG) ? SWEEP : SWAP_WAIT;
            SWEEP:      w_next = (r_k == TAGBITS'(NUMNEURONS-1)) ? FLUSH : SWEEP;
            FLUSH:      w_next = w_fin ? IDLE : FLUSH;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_fl        <= '0;
            r_seen_swap <= 1'b0;
            r_rv        <= '0;
            for (int i = 0; i < READ_LAT; i++) r_rt[i] <= '0;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_k         <= w_rd ? r_k + 1'b1 : '0;
            r_fl        <= (r_state == FLUSH) ? r_fl + 2'd1 : 2'd0;
            r_seen_swap <= (r_state == SWAP_WAIT) & (r_seen_swap | (cim_state == CIM_SWAP));
            r_rv        <= {r_rv[READ_LAT-2:0], w_rd};
            r_rt[0]     <= w_rd ? r_k : '0;
            for (int i = 1; i < READ_LAT; i++) r_rt[i] <= r_rt[i-1];
            r_done      <= w_fin;
            if (w_fin) r_cnt <= r_cnt + 1'b1;
            r_ovf       <= r_ovf | (spike_valid & w_full & ~w_pop);
        end

`ifdef CIM_SCHED_STATS_EN
    logic [15:0] r_spk, r_cyc;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_spk       <= '0;
            r_cyc       <= '0;
            stat_spikes <= '0;
            stat_cycles <= '0;
        end else begin
            if (r_state == IDLE && step_start) begin
                r_spk <= '0;
                r_cyc <= 16'd1;
            end else if (r_state != IDLE) begin
                r_cyc <= r_cyc + {15'd0, r_cyc != 16'hFFFF};
                if (r_state == ACCUM && w_pop) r_spk <= r_spk + {15'd0, r_spk != 16'hFFFF};
            end
            if (w_fin) begin
                stat_spikes <= r_spk;
                stat_cycles <= r_cyc + {15'd0, r_cyc != 16'hFFFF};
            end
        end
`endif

    // Ready flags are forced low while reset is held so every output sits at its reset value.
    assign cfg_ready      = reset & (r_state == IDLE) & ~step_start;
    assign spike_ready    = reset & ~w_full;
    assign spike_ovf      = r_ovf;
    assign cim_ld_en      = cfg_valid & cfg_ready;
    assign cim_eff_tag    = cim_ld_en ? cfg_eff : '0;
    assign cim_aff_tag    = cim_ld_en ? cfg_aff : '0;
    assign cim_ld_weight  = cim_ld_en ? cfg_weight : '0;
    assign cim_fifo_empty = w_empty | (r_state != ACCUM);
    assign cim_fired_tag  = w_empty ? '0 : w_head;
    assign cim_swap       = (r_state == SWAP_ISSUE) & (cim_state == CIM_WAIT_TAG);
    assign cim_read_en    = w_rd;
    assign cim_i_tag      = w_rd ? r_k : '0;
    assign cur_valid      = r_rv[READ_LAT-1];
    assign cur_tag        = r_rt[READ_LAT-1];
    assign cur_data       = cur_valid ? cim_i_out : '0;
    assign step_done      = r_done;
    assign step_count     = r_cnt;
endmodule

// File: tb/tb_cim_step_scheduler.sv
// tb_cim_step_scheduler: directed bench for cim_step_scheduler driving a behavioural
// compute-in-memory array (pop/accumulate, swap, 2-cycle current read).
module tb_cim_step_scheduler;
    localparam logic [1:0] WT = 2'd0, AC = 2'd1, SW = 2'd2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic step_start = 0, cfg_valid = 0, spike_valid = 0;
    logic [4:0] cfg_eff = 0, cfg_aff = 0, spike_tag = 0;
    logic [16:0] cfg_weight = 0;
    logic step_done, cfg_ready, spike_ready, spike_ovf, cur_valid, cim_ld_en;
    logic cim_fifo_empty, cim_req_deq, cim_swap, cim_read_en, cim_busy;
    logic [15:0] step_count;
    logic [4:0] cur_tag, cim_eff_tag, cim_aff_tag, cim_fired_tag, cim_i_tag;
    logic [16:0] cur_data, cim_ld_weight, cim_i_out;
    logic [1:0] cim_state;
`ifdef CIM_SCHED_STATS_EN
    logic [15:0] stat_spikes, stat_cycles;
`endif

    always #5 clk = ~clk;

    cim_step_scheduler dut (
        .clk(clk), .reset(reset), .step_start(step_start), .step_done(step_done),
        .step_count(step_count), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_eff(cfg_eff), .cfg_aff(cfg_aff), .cfg_weight(cfg_weight),
        .spike_valid(spike_valid), .spike_tag(spike_tag), .spike_ready(spike_ready),
        .spike_ovf(spike_ovf), .cur_valid(cur_valid), .cur_tag(cur_tag), .cur_data(cur_data),
        .cim_ld_en(cim_ld_en), .cim_eff_tag(cim_eff_tag), .cim_aff_tag(cim_aff_tag),
        .cim_ld_weight(cim_ld_weight), .cim_fifo_empty(cim_fifo_empty),
        .cim_fired_tag(cim_fired_tag), .cim_req_deq(cim_req_deq), .cim_swap(cim_swap),
        .cim_read_en(cim_read_en), .cim_i_tag(cim_i_tag),
`ifdef CIM_SCHED_STATS_EN
        .stat_spikes(stat_spikes), .stat_cycles(stat_cycles),
`endif
        .cim_busy(cim_busy), .cim_state(cim_state), .cim_i_out(cim_i_out)
    );

    // Array model: one spike per WAIT_TAG->ACC round trip, swap moves accumulators to readable currents.
    logic [1:0]  a_st;
    logic [4:0]  a_tag;
    logic [16:0] wm [32][32];
    logic [16:0] acc [32];
    logic [16:0] curm [32];
    logic [16:0] rd1;
    assign cim_req_deq = (a_st == WT) && !cim_fifo_empty && !cim_swap;
    assign cim_busy    = a_st == AC;
    assign cim_state   = a_st;

    always @(posedge clk or negedge reset)
        if (!reset) begin
            a_st <= WT;
            a_tag <= '0;
            rd1 <= '0;
            cim_i_out <= '0;
            for (int i = 0; i < 32; i++) begin
                acc[i] <= '0;
                curm[i] <= '0;
                for (int j = 0; j < 32; j++) wm[i][j] <= '0;
            end
        end else begin
            if (cim_ld_en) wm[cim_eff_tag][cim_aff_tag] <= cim_ld_weight;
            case (a_st)
                WT: if (cim_swap) a_st <= SW;
                    else if (cim_req_deq) begin a_st <= AC; a_tag <= cim_fired_tag; end
                AC: begin
                    for (int j = 0; j < 32; j++) acc[j] <= acc[j] + wm[a_tag][j];
                    a_st <= WT;
                end
                default: begin
                    for (int j = 0; j < 32; j++) begin curm[j] <= acc[j]; acc[j] <= '0; end
                    a_st <= WT;
                end
            endcase
            rd1 <= cim_read_en ? curm[cim_i_tag] : '0;
            cim_i_out <= rd1;
        end

    // Monitor: event counters sampled mid-cycle, read by the stimulus after the next posedge.
    logic [16:0] exp_cur [32];
    int cyc = 0, beat_idx = 0, n_beats = 0, n_bad_tag = 0, n_bad_data = 0, n_swap = 0;
    int n_done = 0, n_pop = 0, n_ld = 0, n_sweep_ne = 0;
    int rd_rise = 0, cv_rise = 0, last_cv = 0, done_cyc = 0;
    logic prev_rd = 0, prev_cv = 0;
    always @(negedge clk) begin
        cyc++;
        if (!reset) beat_idx = 0;
        else begin
            if (cur_valid) begin
                n_beats++;
                if (cur_tag !== beat_idx[4:0]) n_bad_tag++;
                if (cur_data !== exp_cur[cur_tag]) n_bad_data++;
                last_cv = cyc;
                beat_idx++;
            end
            if (cim_read_en && !prev_rd) rd_rise = cyc;
            if (cur_valid && !prev_cv) cv_rise = cyc;
            if (cim_swap) n_swap++;
            if (step_done) begin n_done++; done_cyc = cyc; beat_idx = 0; end
            if (cim_req_deq && !cim_fifo_empty) n_pop++;
            if (cim_ld_en) n_ld++;
            if (cim_read_en && !cim_fifo_empty) n_sweep_ne++;
        end
        prev_rd = cim_read_en;
        prev_cv = cur_valid;
    end

    int total = 0, bad = 0;
    int p0, b0, s0, d0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        p0 = n_pop; b0 = n_beats; s0 = n_swap; d0 = n_done;
    endtask

    task automatic pulse_start();
        step_start = 1;
        tick();
        step_start = 0;
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (n_done == d0 && k < lim) begin tick(); k++; end
    endtask

    task automatic wait_read(input int lim);
        int k = 0;
        while (!cim_read_en && k < lim) begin tick(); k++; end
    endtask

    task automatic chk_step(input int pops, input int cnt);
        chk("pops", n_pop - p0, pops);
        chk("beats", n_beats - b0, 32);
        chk("beat_tag_errors", n_bad_tag, 0);
        chk("beat_data_errors", n_bad_data, 0);
        chk("swap_pulses", n_swap - s0, 1);
        chk("done_pulses", n_done - d0, 1);
        chk("step_count", 32'(step_count), cnt);
        chk("read_to_valid", cv_rise - rd_rise, 2);
        chk("done_after_last_beat", done_cyc - last_cv, 1);
    endtask

    task automatic set_exp(input int t1, input int v1, input int t2, input int v2);
        for (int i = 0; i < 32; i++) exp_cur[i] = '0;
        exp_cur[t1] = 17'(v1);
        exp_cur[t2] = 17'(v2);
    endtask

    initial begin
        int accn;
        set_exp(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_spike_ready", spike_ready, 0);
        chk("rst_fifo_empty", cim_fifo_empty, 1);
        chk("rst_step_count", step_count, 0);
        chk("rst_ovf", spike_ovf, 0);
        chk("rst_cur_valid", cur_valid, 0);
        chk("rst_done", step_done, 0);
        tick();
        reset = 1;
        @(negedge clk);
        chk("idle_cfg_ready", cfg_ready, 1);
        chk("idle_spike_ready", spike_ready, 1);

        // Weights mem[3][7]=5 and mem[4][2]=9
        tick();
        cfg_valid = 1; cfg_eff = 3; cfg_aff = 7; cfg_weight = 5;
        @(negedge clk);
        chk("ld_en", cim_ld_en, 1);
        chk("ld_eff", cim_eff_tag, 3);
        chk("ld_aff", cim_aff_tag, 7);
        chk("ld_weight", cim_ld_weight, 5);
        tick();
        cfg_eff = 4; cfg_aff = 2; cfg_weight = 9;
        tick();
        cfg_valid = 0;
        spike_valid = 1; spike_tag = 3;
        tick();
        spike_valid = 0;
        @(negedge clk);
        chk("fired_tag_head", cim_fired_tag, 3);
        chk("idle_fifo_hidden", cim_fifo_empty, 1);

        // Step 1: step_start wins over cfg_valid; spike 3 yields current 5 on tag 7
        set_exp(7, 5, 0, 0);
        tick();
        snap();
        step_start = 1; cfg_valid = 1; cfg_eff = 1; cfg_aff = 1; cfg_weight = 77;
        @(negedge clk);
        chk("start_cfg_ready", cfg_ready, 0);
        chk("start_ld_en", cim_ld_en, 0);
        tick();
        step_start = 0; cfg_valid = 0;
        @(negedge clk);
        chk("accum_fifo_visible", cim_fifo_empty, 0);
        wait_done(300);
        chk_step(1, 1);
        chk("ld_count", n_ld, 2);

        // Step 2: empty FIFO, spike 4 pushed during the sweep stays queued
        set_exp(0, 0, 0, 0);
        snap();
        pulse_start();
        wait_read(100);
        spike_valid = 1; spike_tag = 4;
        tick();
        spike_valid = 0;
        wait_done(300);
        chk_step(0, 2);
        chk("sweep_fifo_hidden", n_sweep_ne, 0);
        @(negedge clk);
        chk("queued_head", cim_fired_tag, 4);

        // Step 3: the queued spike 4 is consumed, current 9 on tag 2
        set_exp(2, 9, 0, 0);
        tick();
        snap();
        pulse_start();
        wait_done(300);
        chk_step(1, 3);

        // Step 4: reset mid-sweep
        set_exp(0, 0, 0, 0);
        snap();
        pulse_start();
        wait_read(100);
        repeat (5) tick();
        reset = 0;
        #1;
        chk("mid_rst_read_en", cim_read_en, 0);
        chk("mid_rst_cur_valid", cur_valid, 0);
        chk("mid_rst_i_tag", cim_i_tag, 0);
        chk("mid_rst_fifo_empty", cim_fifo_empty, 1);
        chk("mid_rst_step_count", step_count, 0);
        chk("mid_rst_done", step_done, 0);
        repeat (2) tick();
        reset = 1;
        repeat (60) tick();
        chk("no_done_after_rst", n_done - d0, 0);
        chk("count_after_rst", step_count, 0);

        // Overflow: 40 pushes in IDLE, 32 accepted
        cfg_valid = 1; cfg_eff = 3; cfg_aff = 7; cfg_weight = 5;
        tick();
        cfg_valid = 0;
        @(negedge clk);
        chk("ovf_clear", spike_ovf, 0);
        tick();
        accn = 0;
        for (int i = 0; i < 40; i++) begin
            spike_valid = 1; spike_tag = 5'(i);
            @(negedge clk);
            if (spike_ready) accn++;
            tick();
        end
        spike_valid = 0;
        @(negedge clk);
        chk("accepted", accn, 32);
        chk("full_not_ready", spike_ready, 0);
        chk("ovf_set", spike_ovf, 1);
        repeat (3) tick();
        chk("ovf_sticky", spike_ovf, 1);

        // Step 5: push tag 3 while full during a pop; 33 pops, tag 7 accumulates twice
        set_exp(7, 10, 0, 0);
        snap();
        pulse_start();
        spike_valid = 1; spike_tag = 3;
        @(negedge clk);
        chk("full_pop_deq", cim_req_deq, 1);
        chk("full_pop_ready", spike_ready, 0);
        tick();
        spike_valid = 0;
        wait_done(400);
        chk_step(33, 1);
        chk("ovf_final", spike_ovf, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end
endmodule
